// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pipe_pkg
//   Shared definitions for the pipelined signed ALU: the 3-bit opcode encoding
//   used by the RTL and by any reference model or stimulus generator.
// -----------------------------------------------------------------------------
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        ADD      = 3'd0,
        SUB      = 3'd1,
        INV_A    = 3'd2,
        RED_OR_B = 3'd3,
        AND      = 3'd4,
        OR       = 3'd5,
        XOR      = 3'd6,
        LT       = 3'd7
    } opcode_t;

endpackage : alu_pipe_pkg

// File: rtl/alu_pipe_core.sv
// -----------------------------------------------------------------------------
// alu_pipe_core
//   Purely combinational W-bit signed ALU datapath. Produces a W+1-bit result
//   and zero/negative/overflow flags.
//   Optional feature macro: ALU_SAT_EN (adds the sat input; ADD/SUB clamp to
//   the W-bit signed range when sat=1).
// Ports
//   opcode  in   3    operation select (alu_pipe_pkg::opcode_t)
//   a, b    in   W    signed operands
//   sat     in   1    saturate ADD/SUB (only with ALU_SAT_EN)
//   c       out  W+1  signed result
//   z, n, v out  1    zero, negative (c[W]), ADD/SUB signed overflow
// -----------------------------------------------------------------------------
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int W = 4
) (
    input  opcode_t        opcode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef ALU_SAT_EN
    input  logic           sat,
`endif
    output logic [W:0]     c,
    output logic           z,
    output logic           n,
    output logic           v
);

    logic           sat_s;
    logic [W:0]     a_x_s;
    logic [W:0]     b_x_s;
    logic [W:0]     sum_s;
    logic [W:0]     dif_s;
    logic [W:0]     pos_max_s;
    logic [W:0]     neg_min_s;
    logic           ovf_add_s;
    logic           ovf_sub_s;
    logic [W:0]     res_s;
    logic           v_s;

`ifdef ALU_SAT_EN
    assign sat_s = sat;
`else
    assign sat_s = 1'b0;
`endif

    // Sign-extended arithmetic; a W+1-bit sum never wraps, so overflow of the
    // W-bit range shows up as the top two bits disagreeing.
    always_comb begin
        a_x_s     = {a[W-1], a};
        b_x_s     = {b[W-1], b};
        sum_s     = a_x_s + b_x_s;
        dif_s     = a_x_s - b_x_s;
        ovf_add_s = sum_s[W] ^ sum_s[W-1];
        ovf_sub_s = dif_s[W] ^ dif_s[W-1];
        pos_max_s = {2'b00, {(W-1){1'b1}}};
        neg_min_s = {2'b11, {(W-1){1'b0}}};
    end

    // Opcode decode; saturation direction follows the sign of the true result.
    always_comb begin
        res_s = {(W+1){1'b0}};
        v_s   = 1'b0;
        case (opcode)
            ADD: begin
                v_s = ovf_add_s;
                if (sat_s && ovf_add_s) begin
                    res_s = sum_s[W] ? neg_min_s : pos_max_s;
                end else begin
                    res_s = sum_s;
                end
            end
            SUB: begin
                v_s = ovf_sub_s;
                if (sat_s && ovf_sub_s) begin
                    res_s = dif_s[W] ? neg_min_s : pos_max_s;
                end else begin
                    res_s = dif_s;
                end
            end
            INV_A:    res_s = ~a_x_s;
            RED_OR_B: res_s = {{W{1'b0}}, |b};
            AND:      res_s = a_x_s & b_x_s;
            OR:       res_s = a_x_s | b_x_s;
            XOR:      res_s = a_x_s ^ b_x_s;
            LT:       res_s = {{W{1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                res_s = {(W+1){1'b0}};
                v_s   = 1'b0;
            end
        endcase
    end

    // Flags derived from the final (possibly clamped) result.
    always_comb begin
        c = res_s;
        z = (res_s == {(W+1){1'b0}});
        n = res_s[W];
        v = v_s;
    end

endmodule : alu_pipe_core

// File: rtl/alu_pipe_w.sv
// -----------------------------------------------------------------------------
// alu_pipe_w
//   Two-stage pipelined signed ALU with valid/ready handshakes on both sides.
//   S1 registers the transaction, S2 registers the computed result and flags.
//   Latency 2 cycles, throughput 1 per cycle, order preserved under stalls.
//   Optional feature macro: ALU_SAT_EN (adds sat_mode, captured with the
//   transaction, saturating ADD/SUB).
// Ports
//   clk        in   1    rising-edge clock
//   reset      in   1    asynchronous active-low reset
//   in_valid   in   1    operand transaction valid
//   in_ready   out  1    transaction accepted this cycle if in_valid
//   opcode     in   3    alu_pipe_pkg::opcode_t
//   A, B       in   W    signed operands
//   sat_mode   in   1    saturate ADD/SUB (only with ALU_SAT_EN)
//   out_valid  out  1    result valid (held until out_ready)
//   out_ready  in   1    consumer takes the result this cycle
//   C          out  W+1  signed result
//   flag_z/n/v out  1    zero, negative, ADD/SUB overflow
// -----------------------------------------------------------------------------
module alu_pipe_w
    import alu_pipe_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  opcode_t        opcode,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
`ifdef ALU_SAT_EN
    input  logic           sat_mode,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     C,
    output logic           flag_z,
    output logic           flag_n,
    output logic           flag_v
);

    logic           s1_valid_r;
    opcode_t        s1_op_r;
    logic [W-1:0]   s1_a_r;
    logic [W-1:0]   s1_b_r;
`ifdef ALU_SAT_EN
    logic           s1_sat_r;
`endif
    logic           s2_ready_s;
    logic           in_fire_s;
    logic [W:0]     core_c_s;
    logic           core_z_s;
    logic           core_n_s;
    logic           core_v_s;

    // Backpressure chain: S2 frees up when empty or being drained, S1 when
    // empty or able to move into S2.
    always_comb begin
        s2_ready_s = !out_valid || out_ready;
        in_ready   = !s1_valid_r || s2_ready_s;
        in_fire_s  = in_valid && in_ready;
    end

    // Stage 1: capture the transaction; drop valid once it has moved on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= ADD;
            s1_a_r     <= {W{1'b0}};
            s1_b_r     <= {W{1'b0}};
`ifdef ALU_SAT_EN
            s1_sat_r   <= 1'b0;
`endif
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= opcode;
            s1_a_r     <= A;
            s1_b_r     <= B;
`ifdef ALU_SAT_EN
            s1_sat_r   <= sat_mode;
`endif
        end else if (s2_ready_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    alu_pipe_core #(
        .W      (W)
    ) u_core (
        .opcode (s1_op_r),
        .a      (s1_a_r),
        .b      (s1_b_r),
`ifdef ALU_SAT_EN
        .sat    (s1_sat_r),
`endif
        .c      (core_c_s),
        .z      (core_z_s),
        .n      (core_n_s),
        .v      (core_v_s)
    );

    // Stage 2: register result and flags; everything holds while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            C         <= {(W+1){1'b0}};
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
        end else if (s2_ready_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                C      <= core_c_s;
                flag_z <= core_z_s;
                flag_n <= core_n_s;
                flag_v <= core_v_s;
            end else begin
                C      <= C;
                flag_z <= flag_z;
                flag_n <= flag_n;
                flag_v <= flag_v;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule : alu_pipe_w
